// File: rtl/johnson_pkg.sv
// Shared constants and phase/pattern helpers for the parametrised Johnson counter.
// Helpers work on a MAX_W-bit container so any ring width up to MAX_W can reuse them.
package johnson_pkg;

  localparam int   MAX_W    = 32;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Phase k<=width: k MSBs set; phase width+j: j MSBs clear, remainder set.
  function automatic logic [MAX_W-1:0] phase_to_q(input int phase, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        if (phase <= width) r[i] = ((width - 1 - i) < phase);
        else                r[i] = ((width - 1 - i) >= (phase - width));
      end
    end
    return r;
  endfunction

  function automatic int q_to_phase(input logic [MAX_W-1:0] q, input int width);
    int pc;
    pc = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) pc += int'(q[i]);
    end
    return q[0] ? (2 * width - pc) : pc;
  endfunction

  // Legal iff the ones are a contiguous run anchored at the LSB or at the MSB.
  function automatic bit q_is_legal(input logic [MAX_W-1:0] q, input int width);
    logic [MAX_W-1:0] mask, qm, nq;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    qm   = q & mask;
    nq   = ~q & mask;
    return ((qm & (qm + MAX_W'(1))) == '0) || ((nq & (nq + MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of the ring state into binary phase, one-hot phase and a legality flag.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   q_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic [2*WIDTH-1:0] phase_onehot_o,
  output logic               legal_o
);

  logic [MAX_W-1:0] q_ext;
  assign q_ext = MAX_W'(q_i);

  always_comb begin
    legal_o        = q_is_legal(q_ext, WIDTH);
    phase_o        = PHASE_W'(q_to_phase(q_ext, WIDTH));
    phase_onehot_o = '0;
    if (legal_o) phase_onehot_o[phase_o] = 1'b1;
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, phase load,
// decoded phase outputs, wrap pulse and optional illegal-state recovery.
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int  WIDTH   = 4,
  parameter bit  CORRECT = 1'b1,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic               load_i,
  input  logic [PHASE_W-1:0] load_phase_i,
  output logic [WIDTH-1:0]   q_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic [2*WIDTH-1:0] phase_onehot_o,
  output logic               wrap_o,
  output logic               err_o
);

  localparam logic [PHASE_W:0]   MODULUS = (PHASE_W + 1)'(2 * WIDTH);
  localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(2 * WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             legal;
  logic [MAX_W-1:0] load_pat;

  johnson_phase_decode #(
    .WIDTH   (WIDTH),
    .PHASE_W (PHASE_W)
  ) u_decode (
    .q_i            (q_q),
    .phase_o        (phase_o),
    .phase_onehot_o (phase_onehot_o),
    .legal_o        (legal)
  );

  assign load_pat = phase_to_q(int'(load_phase_i), WIDTH);

  // Priority: load > correction > step > hold (reset handled in the flop block).
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load_i) begin
      if ({1'b0, load_phase_i} < MODULUS) begin
        q_d = load_pat[WIDTH-1:0];
      end else begin
        q_d   = '0;
        err_d = 1'b1;
      end
    end else if (!legal && CORRECT) begin
      q_d   = '0;
      err_d = 1'b1;
    end else begin
      err_d = !legal;
      if (en_i) begin
        if (dir_i == DIR_UP) q_d = {~q_q[0], q_q[WIDTH-1:1]};
        else                 q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        // Illegal rings never wrap; only a real phase boundary crossing does.
        wrap_d = legal && ((dir_i == DIR_UP) ? (phase_o == LAST) : (phase_o == '0));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule
